opcode_call_stack: RTL and testbench
====================================

// Module: opcode_call_stack
// PURPOSE
//   LIFO storage for opcodes saved by CALLproc and restored by RET.
//   Answers the push/pop requests issued by the main control block.
//   Top-of-stack is visible combinationally, so the requester samples it in
//   the same cycle it pops. Adds full/empty status, sticky overflow/underflow
//   flags, an occupancy count and a high-water mark for debug.
// PARAMETERS
//   WIDTH  4  bits per stored opcode
//   DEPTH  8  number of entries (>=2)
//   CW     $clog2(DEPTH+1)  count width (localparam, derived)
// PORTS
//   clock       in   1      single clock, all state on rising edge
//   reset       in   1      asynchronous, active-high
//   push        in   1      write write_data onto stack this cycle
//   pop         in   1      remove top entry this cycle
//   write_data  in   WIDTH  value to push
//   clear_err   in   1      synchronous clear of overflow/underflow
//   read_data   out  WIDTH  current top entry, 0 when empty (combinational)
//   empty       out  1      count == 0
//   full        out  1      count == DEPTH
//   count       out  CW     entries held
//   high_water  out  CW     max count reached since reset
//   overflow    out  1      sticky: push rejected while full
//   underflow   out  1      sticky: pop rejected while empty
// BEHAVIOUR
//   Reset (async assert, takes effect immediately):
//   - count, high_water, overflow, underflow = 0; read_data = 0; empty = 1; full = 0.
//   - Storage array is not reset; it is never visible while empty.
//   Top of stack:
//   - read_data = mem[count-1] when count > 0, else 0. Pure function of state.
//   - During a pop cycle, read_data is the entry being removed.
//   Per rising edge, evaluated on pre-edge state:
//   - push only, !full: mem[count] <= write_data; count+1.
//   - push only, full: no write; count unchanged; overflow <= 1.
//   - pop only, !empty: count-1; storage unchanged.
//   - pop only, empty: count unchanged; underflow <= 1.
//   - push & pop, !empty: replace; mem[count-1] <= write_data.
//     count unchanged; no error even when full.
//   - push & pop, empty: the push is performed (count becomes 1); underflow <= 1.
//   - neither: hold.
//   Error flags:
//   - Flags are sticky until clear_err.
//   - clear_err and a new error in the same cycle: the new error wins (flag = 1).
//   - clear_err affects only flags.
//   high_water:
//   - Updates to the post-edge count when that count exceeds it.
//   - It never decreases except on reset.
//   Timing:
//   - Latency push -> visible on read_data: 1 cycle (after the edge).
//   - No handshake stall: every request resolves in its own cycle.
//   - Reset mid-operation discards all entries.
//   Widths:
//   - count arithmetic is in CW bits and cannot wrap, because full and empty guard it.
// TESTING
//   1 Reset, then idle -> empty=1, count=0, read_data=0, all flags 0.
//   2 Push 3,5,9 on consecutive cycles -> count=3, read_data=9, high_water=3.
//     Then 3 pops -> read_data 9,5,3 in the pop cycles; finally empty=1.
//   3 Push 1..8 (DEPTH=8) -> full=1. Push 0xF -> overflow=1, count=8, read_data=8.
//     Pop -> read_data=8 in that cycle, then 7.
//   4 Pop on empty -> underflow=1, count=0.
//     clear_err alone -> underflow=0.
//     clear_err with pop on empty -> underflow stays 1.
//   5 With stack [2,6], push 0xA with pop -> count=2, read_data=A.
//     Push&pop on empty with data 4 -> count=1, read_data=4, underflow=1.
//   6 Push 4 entries, assert reset between edges -> all outputs 0 and empty=1
//     immediately; high_water=0.

Source files
------------

// File: rtl/opcode_call_stack.sv
// opcode_call_stack: LIFO of saved opcodes for CALLproc/RET.
// Top of stack is combinational. Full/empty status, sticky overflow/underflow flags,
// occupancy count and high-water mark are provided for debug.
module opcode_call_stack #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] write_data,
    input  logic             clear_err,
    output logic [WIDTH-1:0] read_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    high_water,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DepthCount = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    high_water_q, high_water_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    top_addr;
    logic [AW-1:0]    next_addr;
    logic             is_empty;
    logic             is_full;

    assign is_empty  = (count_q == '0);
    assign is_full   = (count_q == DepthCount);
    // Only meaningful when non-empty / non-full respectively; guarded below.
    assign top_addr  = AW'(count_q - CW'(1));
    assign next_addr = AW'(count_q);

    // Next-state for count, flags, high-water and the storage write port.
    always_comb begin
        count_d     = count_q;
        overflow_d  = clear_err ? 1'b0 : overflow_q;
        underflow_d = clear_err ? 1'b0 : underflow_q;
        mem_we      = 1'b0;
        mem_waddr   = next_addr;

        if (push && pop) begin
            if (is_empty) begin
                // Pop part fails, push part still lands in slot 0.
                mem_we      = 1'b1;
                mem_waddr   = '0;
                count_d     = CW'(1);
                underflow_d = 1'b1;
            end else begin
                // Replace top in place; legal even when full.
                mem_we    = 1'b1;
                mem_waddr = top_addr;
            end
        end else if (push) begin
            if (is_full) begin
                overflow_d = 1'b1;
            end else begin
                mem_we    = 1'b1;
                mem_waddr = next_addr;
                count_d   = count_q + CW'(1);
            end
        end else if (pop) begin
            if (is_empty) begin
                underflow_d = 1'b1;
            end else begin
                count_d = count_q - CW'(1);
            end
        end

        high_water_d = (count_d > high_water_q) ? count_d : high_water_q;
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            high_water_q <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            high_water_q <= high_water_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage array is deliberately not reset; it is hidden whenever empty.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= write_data;
        end
    end

    assign read_data  = is_empty ? '0 : mem_q[top_addr];
    assign empty      = is_empty;
    assign full       = is_full;
    assign count      = count_q;
    assign high_water = high_water_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_opcode_call_stack.sv
// Randomized plus directed bench for opcode_call_stack against a queue-based model.
module tb_opcode_call_stack;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clock;
    logic             reset;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] write_data;
    logic             clear_err;
    logic [WIDTH-1:0] read_data;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic [CW-1:0]    high_water;
    logic             overflow;
    logic             underflow;

    opcode_call_stack #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .write_data (write_data),
        .clear_err  (clear_err),
        .read_data  (read_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .high_water (high_water),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model
    int unsigned m_stack[$];
    int unsigned m_hw;
    bit          m_ovf;
    bit          m_unf;

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned m_top();
        return (m_stack.size() == 0) ? 0 : m_stack[$];
    endfunction

    task automatic m_reset();
        m_stack.delete();
        m_hw  = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".count"},      count,      m_stack.size());
        check_eq({tag, ".empty"},      empty,      (m_stack.size() == 0) ? 1 : 0);
        check_eq({tag, ".full"},       full,       (m_stack.size() == DEPTH) ? 1 : 0);
        check_eq({tag, ".read_data"},  read_data,  m_top());
        check_eq({tag, ".high_water"}, high_water, m_hw);
        check_eq({tag, ".overflow"},   overflow,   m_ovf);
        check_eq({tag, ".underflow"},  underflow,  m_unf);
    endtask

    // One request cycle; starts and ends 1 time unit after a rising edge.
    task automatic do_cycle(input bit p, input bit q, input int unsigned d, input bit clr,
                            input string tag);
        bit e_ovf;
        bit e_unf;
        push       = p;
        pop        = q;
        write_data = WIDTH'(d);
        clear_err  = clr;
        #1;
        check_eq({tag, ".pre_read"}, read_data, m_top());
        @(posedge clock);
        e_ovf = 0;
        e_unf = 0;
        if (p && q) begin
            if (m_stack.size() == 0) begin
                m_stack.push_back(d % 16);
                e_unf = 1;
            end else begin
                m_stack[m_stack.size() - 1] = d % 16;
            end
        end else if (p) begin
            if (m_stack.size() == DEPTH) e_ovf = 1;
            else m_stack.push_back(d % 16);
        end else if (q) begin
            if (m_stack.size() == 0) e_unf = 1;
            else void'(m_stack.pop_back());
        end
        m_ovf = e_ovf | (m_ovf & !clr);
        m_unf = e_unf | (m_unf & !clr);
        if (m_stack.size() > m_hw) m_hw = m_stack.size();
        #1;
        push      = 0;
        pop       = 0;
        clear_err = 0;
        check_all(tag);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear immediately.
    task automatic do_reset(input string tag);
        #3;
        reset = 1'b1;
        #1;
        m_reset();
        check_all(tag);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        push       = 0;
        pop        = 0;
        write_data = '0;
        clear_err  = 0;
        m_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // 1: idle after reset
        do_cycle(0, 0, 0, 0, "t1_idle");
        check_eq("t1_empty", empty, 1);

        // 2: push 3,5,9 then pop three times
        do_cycle(1, 0, 3, 0, "t2_push");
        do_cycle(1, 0, 5, 0, "t2_push");
        do_cycle(1, 0, 9, 0, "t2_push");
        check_eq("t2_count", count, 3);
        check_eq("t2_top", read_data, 9);
        check_eq("t2_hw", high_water, 3);
        do_cycle(0, 1, 0, 0, "t2_pop");
        do_cycle(0, 1, 0, 0, "t2_pop");
        do_cycle(0, 1, 0, 0, "t2_pop");
        check_eq("t2_empty", empty, 1);

        // 3: fill, overflow, pop from full
        for (int i = 1; i <= DEPTH; i++) do_cycle(1, 0, i, 0, "t3_fill");
        check_eq("t3_full", full, 1);
        do_cycle(1, 0, 15, 0, "t3_ovf");
        check_eq("t3_ovf", overflow, 1);
        check_eq("t3_top", read_data, 8);
        do_cycle(0, 1, 0, 0, "t3_pop");
        check_eq("t3_top_after", read_data, 7);
        for (int i = 0; i < DEPTH - 1; i++) do_cycle(0, 1, 0, 0, "t3_drain");
        do_cycle(0, 0, 0, 1, "t3_clr");

        // 4: underflow and clear_err priority
        do_cycle(0, 1, 0, 0, "t4_unf");
        check_eq("t4_unf", underflow, 1);
        do_cycle(0, 0, 0, 1, "t4_clr");
        check_eq("t4_clr", underflow, 0);
        do_cycle(0, 1, 0, 1, "t4_clr_vs_err");
        check_eq("t4_err_wins", underflow, 1);
        do_cycle(0, 0, 0, 1, "t4_clr2");

        // 5: replace and push&pop on empty
        do_cycle(1, 0, 2, 0, "t5_push");
        do_cycle(1, 0, 6, 0, "t5_push");
        do_cycle(1, 1, 10, 0, "t5_replace");
        check_eq("t5_rep_count", count, 2);
        check_eq("t5_rep_top", read_data, 10);
        do_cycle(0, 1, 0, 0, "t5_pop");
        do_cycle(0, 1, 0, 0, "t5_pop");
        do_cycle(1, 1, 4, 0, "t5_pp_empty");
        check_eq("t5_pp_top", read_data, 4);
        check_eq("t5_pp_unf", underflow, 1);

        // 6: reset mid-operation
        for (int i = 0; i < 4; i++) do_cycle(1, 0, i + 1, 0, "t6_push");
        do_reset("t6_reset");
        check_eq("t6_hw", high_water, 0);

        // Random traffic with occasional clears and resets
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            bit p;
            bit q;
            r = $urandom_range(0, 99);
            // Drift the bias so the stack regularly reaches both ends.
            if ((n / 200) % 2 == 0) begin
                p = (r < 60);
                q = ($urandom_range(0, 99) < 35);
            end else begin
                p = (r < 35);
                q = ($urandom_range(0, 99) < 60);
            end
            do_cycle(p, q, $urandom_range(0, 15), ($urandom_range(0, 19) == 0), "rnd");
            if ($urandom_range(0, 499) == 0) do_reset("rnd_reset");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
